// File: rtl/fp_mul_arbiter.sv
// Round-robin front end that time-shares one fully pipelined fp_mul between N_REQ requesters.
// Each issued operation carries its requester ID down a tag pipeline matched to the multiplier latency.
module fp_mul_arbiter #(
    parameter int N_REQ       = 4,
    parameter int MUL_LATENCY = 3,
    parameter int ID_W        = $clog2(N_REQ),
    parameter int CNT_W       = $clog2(MUL_LATENCY + 2)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*32-1:0]   req_a,
    input  logic [N_REQ*32-1:0]   req_b,
    output logic [N_REQ-1:0]      req_ready,
    output logic [N_REQ-1:0]      resp_valid,
    output logic [31:0]           resp_data,
    output logic [31:0]           mul_num1,
    output logic [31:0]           mul_num2,
    input  logic [31:0]           mul_s,
    output logic [CNT_W-1:0]      in_flight,
    output logic                  idle
);

    localparam int SUM_W = ID_W + 1;

    logic [ID_W-1:0]                  rr_q, rr_d;
    logic [31:0]                      num1_q, num1_d;
    logic [31:0]                      num2_q, num2_d;
    logic [MUL_LATENCY-1:0]           tag_vld_q, tag_vld_d;
    logic [MUL_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;
    logic [N_REQ-1:0]                 resp_valid_q, resp_valid_d;
    logic [31:0]                      resp_data_q, resp_data_d;
    logic [CNT_W-1:0]                 in_flight_q, in_flight_d;

    logic [N_REQ-1:0] rot;
    logic             grant_found;
    logic             fire;
    logic             ret;
    logic [ID_W-1:0]  grant_id;
    logic [SUM_W-1:0] sum;

    // Rotate requests so bit 0 is the current priority holder, then take the first set bit.
    always_comb begin
        rot         = N_REQ'({req_valid, req_valid} >> rr_q);
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!grant_found && rot[k]) begin
                grant_found = 1'b1;
                sum = {1'b0, rr_q} + SUM_W'(k);
                if (sum >= SUM_W'(N_REQ)) begin
                    sum = sum - SUM_W'(N_REQ);
                end
                grant_id = sum[ID_W-1:0];
            end
        end
        fire      = grant_found && en && rstn;
        req_ready = fire ? (N_REQ'(1) << grant_id) : '0;
    end

    always_comb begin
        rr_d   = rr_q;
        num1_d = num1_q;
        num2_d = num2_q;
        if (fire) begin
            rr_d = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
            for (int k = 0; k < N_REQ; k++) begin
                if (grant_id == ID_W'(k)) begin
                    num1_d = req_a[32*k +: 32];
                    num2_d = req_b[32*k +: 32];
                end
            end
        end

        tag_vld_d[0] = fire;
        tag_id_d[0]  = grant_id;
        for (int k = 1; k < MUL_LATENCY; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end

        // The last tag stage lines up with the multiplier output on this edge.
        ret          = tag_vld_q[MUL_LATENCY-1];
        resp_valid_d = ret ? (N_REQ'(1) << tag_id_q[MUL_LATENCY-1]) : '0;
        resp_data_d  = ret ? mul_s : resp_data_q;

        in_flight_d = in_flight_q;
        if (fire && !ret) begin
            in_flight_d = in_flight_q + 1'b1;
        end else if (!fire && ret) begin
            in_flight_d = in_flight_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q         <= '0;
            num1_q       <= '0;
            num2_q       <= '0;
            tag_vld_q    <= '0;
            tag_id_q     <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            in_flight_q  <= '0;
        end else begin
            rr_q         <= rr_d;
            num1_q       <= num1_d;
            num2_q       <= num2_d;
            tag_vld_q    <= tag_vld_d;
            tag_id_q     <= tag_id_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            in_flight_q  <= in_flight_d;
        end
    end

    assign mul_num1   = num1_q;
    assign mul_num2   = num2_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign in_flight  = in_flight_q;
    assign idle       = (in_flight_q == '0) && (req_valid == '0);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Scoreboard bench for fp_mul_arbiter with a behavioural 3-stage single-precision multiplier stub.
module tb_fp_mul_arbiter;

    localparam int N = 4;
    localparam int L = 3;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } op_t;

    typedef struct {
        int          id;
        logic [31:0] data;
        int          issue;
        int          due;
    } sb_t;

    logic           clk = 1'b0;
    logic           rstn;
    logic           en;
    logic [N-1:0]   req_valid;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   resp_valid;
    logic [31:0]    resp_data;
    logic [31:0]    mul_num1;
    logic [31:0]    mul_num2;
    logic [31:0]    mul_s;
    logic [2:0]     in_flight;
    logic           idle;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   p = 0;
    int   max_if = 0;
    op_t  ops[4];
    op_t  pend[N][16];
    int   head[N];
    int   tail[N];
    sb_t  sb[$];
    int   grant_log[$];
    logic [31:0] s_pipe0 = '0;
    logic [31:0] s_pipe1 = '0;

    fp_mul_arbiter #(.N_REQ(N), .MUL_LATENCY(L)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_data(resp_data),
        .mul_num1(mul_num1), .mul_num2(mul_num2), .mul_s(mul_s),
        .in_flight(in_flight), .idle(idle)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Round-to-nearest-even multiply for normal operands; zero/denormal inputs give a signed zero.
    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        logic        sign;
        int          e;
        logic [47:0] prod;
        logic [23:0] m;
        logic        g;
        logic        s;
        sign = a[31] ^ b[31];
        if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {sign, 31'd0};
        prod = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        e = int'(a[30:23]) + int'(b[30:23]) - 127;
        if (prod[47]) begin
            m = {1'b0, prod[46:24]};
            g = prod[23];
            s = |prod[22:0];
            e = e + 1;
        end else begin
            m = {1'b0, prod[45:23]};
            g = prod[22];
            s = |prod[21:0];
        end
        if (g && (s || m[0])) m = m + 24'd1;
        if (m[23]) begin
            m = '0;
            e = e + 1;
        end
        return {sign, 8'(e), m[22:0]};
    endfunction

    always @(posedge clk) begin
        s_pipe0 <= fmul(mul_num1, mul_num2);
        s_pipe1 <= s_pipe0;
    end
    assign mul_s = s_pipe1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic applyStimulus(input int id, input op_t op);
        pend[id][4'(tail[id])] = op;
        tail[id]++;
    endtask

    function automatic bit anyPending();
        for (int i = 0; i < N; i++) if (head[i] != tail[i]) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: present queued requests, predict the grant, record the handshake in the scoreboard.
    task automatic stepCycle();
        int          g;
        int          idx;
        logic [31:0] ga;
        logic [31:0] gb;
        logic [N-1:0] exp_ready;
        ga = '0;
        gb = '0;
        for (int i = 0; i < N; i++) begin
            if (head[i] != tail[i]) begin
                req_valid[i]      = 1'b1;
                req_a[32*i +: 32] = pend[i][4'(head[i])].a;
                req_b[32*i +: 32] = pend[i][4'(head[i])].b;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
        @(negedge clk);
        g = -1;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = (p + k) % N;
                if (g < 0 && req_valid[idx]) g = idx;
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
        grant_log.push_back(g);
        if (g >= 0) begin
            ga = pend[g][4'(head[g])].a;
            gb = pend[g][4'(head[g])].b;
            sb.push_back('{g, pend[g][4'(head[g])].exp, cyc + 1, cyc + 1 + L});
            head[g]++;
            p = (g + 1) % N;
        end
        @(posedge clk);
        #1;
        if (g >= 0) begin
            checkOutput("mul_num1", mul_num1, ga);
            checkOutput("mul_num2", mul_num2, gb);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() > 0 || anyPending()) && n < 60) begin
            stepCycle();
            n++;
        end
        checkOutput("drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic checkGrants(input string tag, input int exp[$]);
        checkOutput({tag, "_len"}, 32'(grant_log.size()), 32'(exp.size()));
        for (int k = 0; k < exp.size() && k < grant_log.size(); k++) begin
            checkOutput(tag, 32'(grant_log[k]), 32'(exp[k]));
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, 32'(req_ready), 32'd0);
        checkOutput({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        checkOutput({tag, "_resp_data"}, resp_data, 32'd0);
        checkOutput({tag, "_num1"}, mul_num1, 32'd0);
        checkOutput({tag, "_num2"}, mul_num2, 32'd0);
        checkOutput({tag, "_in_flight"}, 32'(in_flight), 32'd0);
        checkOutput({tag, "_idle"}, 32'(idle), 32'(req_valid == '0));
    endtask

    // Response side: pops the scoreboard when an entry is due and tracks in-flight occupancy.
    always @(negedge clk) begin
        int  cnt;
        sb_t e;
        if (rstn) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                checkOutput("resp_valid", 32'(resp_valid), 32'(N'(1) << e.id));
                checkOutput("resp_data", resp_data, e.data);
            end else begin
                checkOutput("resp_quiet", 32'(resp_valid), 32'd0);
            end
            cnt = 0;
            foreach (sb[k]) if (sb[k].issue <= cyc) cnt++;
            checkOutput("in_flight", 32'(in_flight), 32'(cnt));
            checkOutput("idle", 32'(idle), 32'((cnt == 0) && (req_valid == '0)));
            if (int'(in_flight) > max_if) max_if = int'(in_flight);
        end
    end

    initial begin
        int exp_seq[$];
        ops[0] = '{32'h40000000, 32'h40400000, 32'h40C00000};
        ops[1] = '{32'h3FC00000, 32'hC0800000, 32'hC0C00000};
        ops[2] = '{32'h3F000000, 32'h3F000000, 32'h3E800000};
        ops[3] = '{32'h3F800000, 32'h80000000, 32'h80000000};
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        rstn      = 1'b0;
        en        = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        #2;
        checkResetState("reset");
        @(posedge clk);
        #1;
        rstn = 1'b1;
        en   = 1'b1;

        $display("[TB] single op on requester 1");
        grant_log.delete();
        applyStimulus(1, ops[0]);
        stepCycle();
        checkGrants("grant_single", '{1});
        drain();

        $display("[TB] datapath check on requester 0");
        applyStimulus(0, '{32'h3F8E147B, 32'h412547AE, 32'h413775F7});
        grant_log.delete();
        stepCycle();
        checkGrants("grant_datapath", '{0});
        drain();

        // Pointer is now 1; one op from requester 3 brings it back to 0.
        applyStimulus(3, ops[3]);
        drain();

        $display("[TB] contention, all four requesters");
        max_if = 0;
        for (int r = 0; r < 2; r++) for (int i = 0; i < N; i++) applyStimulus(i, ops[i]);
        grant_log.delete();
        for (int c = 0; c < 8; c++) stepCycle();
        checkGrants("grant_contention", '{0, 1, 2, 3, 0, 1, 2, 3});
        drain();
        checkOutput("in_flight_max", 32'(max_if), 32'd3);

        $display("[TB] fairness and wrap");
        applyStimulus(2, ops[2]);
        stepCycle();
        applyStimulus(0, ops[0]);
        applyStimulus(3, ops[3]);
        grant_log.delete();
        stepCycle();
        stepCycle();
        checkGrants("grant_wrap", '{3, 0});
        for (int i = 0; i < 3; i++) applyStimulus(0, ops[i]);
        grant_log.delete();
        for (int c = 0; c < 3; c++) stepCycle();
        checkGrants("grant_single_req", '{0, 0, 0});
        drain();

        $display("[TB] enable gating");
        for (int i = 0; i < N; i++) applyStimulus(i, ops[i]);
        applyStimulus(1, ops[2]);
        for (int c = 0; c < 3; c++) stepCycle();
        en = 1'b0;
        grant_log.delete();
        for (int c = 0; c < 6; c++) stepCycle();
        checkGrants("grant_gated", '{-1, -1, -1, -1, -1, -1});
        checkOutput("ready_gated", 32'(req_ready), 32'd0);
        checkOutput("idle_pending", 32'(idle), 32'd0);
        checkOutput("gated_drained", 32'(sb.size()), 32'd0);
        en = 1'b1;
        drain();

        $display("[TB] reset mid-flight");
        applyStimulus(0, ops[0]);
        applyStimulus(1, ops[1]);
        stepCycle();
        stepCycle();
        rstn = 1'b0;
        #1;
        checkResetState("midreset");
        sb.delete();
        p = 0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int c = 0; c < 6; c++) stepCycle();
        applyStimulus(1, ops[1]);
        applyStimulus(2, ops[2]);
        grant_log.delete();
        stepCycle();
        stepCycle();
        checkGrants("grant_after_reset", '{1, 2});
        drain();
        for (int c = 0; c < 2; c++) stepCycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
